cdc_handshake_sender: RTL and testbench

CDC_HANDSHAKE_SENDER -- requirements
Module: cdc_handshake_sender

---
 rtl/cdc_pkg.sv | 18 +
 rtl/cdc_handshake_sender_if.sv | 40 ++++
 rtl/cdc_sync.sv | 25 ++
 rtl/cdc_handshake_sender.sv | 98 +++++++++
 tb/tb_cdc_handshake_sender.sv | 315 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cdc_pkg.sv
// Shared types and constants for the CDC handshake sender and its matching receiver.
package cdc_pkg;

  // Default depth of the ack synchronizer chain (legal range 2..4).
  localparam int SYNC_STAGES_DEFAULT = 2;

  // Width of the completed-transfer counter.
  localparam int COUNT_WIDTH = 8;

  // Sender handshake states.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETUP   = 2'd1,
    WAIT_HI = 2'd2,
    WAIT_LO = 2'd3
  } state_t;

endpackage

// File: rtl/cdc_handshake_sender_if.sv
// Bundles the source-side valid/ready bus and the 4-phase foreign-domain handshake.
// The master modport is the sender's view; the slave modport is the view of
// whatever sits around it (the source plus the foreign receiver).
interface cdc_handshake_sender_if #(
  parameter int WIDTH = 4
);
  import cdc_pkg::*;

  logic                   in_valid;
  logic                   in_ready;
  logic [WIDTH-1:0]       in_data;
  logic                   req;
  logic [WIDTH-1:0]       xdata;
  logic                   ack;
  logic                   busy;
  logic [COUNT_WIDTH-1:0] sent_count;

  modport master (
    input  in_valid,
    input  in_data,
    input  ack,
    output in_ready,
    output req,
    output xdata,
    output busy,
    output sent_count
  );

  modport slave (
    output in_valid,
    output in_data,
    output ack,
    input  in_ready,
    input  req,
    input  xdata,
    input  busy,
    input  sent_count
  );

endinterface

// File: rtl/cdc_sync.sv
// Multi-flop synchronizer for a single level signal crossing into clk.
// Also used by the matching receiver to bring req into its own domain.
module cdc_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_async,
  output logic o_sync
);

  logic [STAGES-1:0] r_sync;

  // Shift the asynchronous input through the chain; reset clears every stage.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], i_async};
    end
  end

  assign o_sync = r_sync[STAGES-1];

endmodule

// File: rtl/cdc_handshake_sender.sv
// Source-side half of a 4-phase req/ack clock-domain crossing. One payload is
// in flight at a time: it is latched into xdata, req rises one cycle later,
// and the block returns to IDLE only after the synchronized ack has gone
// high and then low again.
module cdc_handshake_sender
  import cdc_pkg::*;
#(
  parameter int WIDTH       = 4,
  parameter int SYNC_STAGES = SYNC_STAGES_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst,
  cdc_handshake_sender_if.master bus
);

  state_t                 r_state;
  state_t                 w_state_next;
  logic                   r_req;
  logic                   w_req_next;
  logic [WIDTH-1:0]       r_xdata;
  logic [WIDTH-1:0]       w_xdata_next;
  logic [COUNT_WIDTH-1:0] r_sent_count;
  logic [COUNT_WIDTH-1:0] w_sent_count_next;
  logic                   w_ack_s;
  logic                   w_in_ready;

  // Raw ack is only ever seen by this synchronizer.
  cdc_sync #(
    .STAGES (SYNC_STAGES)
  ) u_ack_sync (
    .clk     (clk),
    .rst     (rst),
    .i_async (bus.ack),
    .o_sync  (w_ack_s)
  );

  assign w_in_ready = (r_state == IDLE);

  // Next-state and next-register decode; everything holds unless a state says otherwise.
  always_comb begin
    w_state_next      = r_state;
    w_req_next        = r_req;
    w_xdata_next      = r_xdata;
    w_sent_count_next = r_sent_count;
    unique case (r_state)
      IDLE: begin
        // ack is deliberately ignored here so a stray high ack cannot advance us.
        if (bus.in_valid) begin
          w_xdata_next = bus.in_data;
          w_state_next = SETUP;
        end
      end
      SETUP: begin
        // One cycle of settling guarantees xdata is stable before req rises.
        w_req_next   = 1'b1;
        w_state_next = WAIT_HI;
      end
      WAIT_HI: begin
        if (w_ack_s) begin
          w_req_next   = 1'b0;
          w_state_next = WAIT_LO;
        end
      end
      WAIT_LO: begin
        if (!w_ack_s) begin
          w_sent_count_next = r_sent_count + 1'b1;
          w_state_next      = IDLE;
        end
      end
      default: begin
        w_req_next   = 1'b0;
        w_state_next = IDLE;
      end
    endcase
  end

  // State and output registers; reset aborts any transfer in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= IDLE;
      r_req        <= 1'b0;
      r_xdata      <= '0;
      r_sent_count <= '0;
    end else begin
      r_state      <= w_state_next;
      r_req        <= w_req_next;
      r_xdata      <= w_xdata_next;
      r_sent_count <= w_sent_count_next;
    end
  end

  assign bus.in_ready   = w_in_ready;
  assign bus.busy       = !w_in_ready;
  assign bus.req        = r_req;
  assign bus.xdata      = r_xdata;
  assign bus.sent_count = r_sent_count;

endmodule

// File: tb/tb_cdc_handshake_sender.sv
// Bench for cdc_handshake_sender: a model foreign receiver on its own clock,
// a zero-time ack echo mode, and a scoreboard of accepted payloads.
module tb_cdc_handshake_sender;
  import cdc_pkg::*;

  localparam int W       = 4;
  localparam int SS      = 2;
  localparam int EXP_CYC = 3 + 2 * SS;
  localparam int LIMIT   = 2000;

  logic clk = 1'b0;
  logic rst = 1'b0;

  cdc_handshake_sender_if #(.WIDTH(W)) bus ();

  cdc_handshake_sender #(
    .WIDTH       (W),
    .SYNC_STAGES (SS)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Foreign-domain receiver model
  logic rclk    = 1'b0;
  int   rx_half = 9;
  always begin
    #(rx_half) rclk = ~rclk;
  end

  int   ack_mode  = 2;   // 0: receiver model, 1: zero-time echo of req, 2: forced
  logic ack_force = 1'b0;
  bit   rx_stall  = 1'b0;
  logic rx_ack, rx_s1, rx_s2;

  assign bus.ack = (ack_mode == 1) ? bus.req : (ack_mode == 2) ? ack_force : rx_ack;

  // Scoreboard and counters
  logic [W-1:0] exp_q[$];
  int checks   = 0;
  int errors   = 0;
  int captures = 0;
  int exp_count = 0;
  int req_rises = 0;
  int xdata_bad = 0;
  logic [W-1:0] cur_data = '0;
  logic req_prev = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic pop_check(input string name, input logic [W-1:0] act);
    logic [W-1:0] e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: got %0h expected no transfer", name, act);
    end else begin
      e = exp_q.pop_front();
      captures++;
      $display("xfer %0d: %s data=%0h expected=%0h count=%0d", captures, name, act, e, bus.sent_count);
      check(name, {28'd0, act}, {28'd0, e});
    end
  endtask

  // Receiver: synchronize req, capture on its rise, answer with ack.
  always @(posedge rclk or negedge rst) begin
    if (!rst) begin
      rx_s1  <= 1'b0;
      rx_s2  <= 1'b0;
      rx_ack <= 1'b0;
    end else begin
      rx_s1 <= bus.req;
      rx_s2 <= rx_s1;
      if (ack_mode != 0) begin
        rx_ack <= 1'b0;
      end else if (rx_s2 && !rx_ack && !rx_stall) begin
        rx_ack <= 1'b1;
        pop_check("rx_capture", bus.xdata);
      end else if (!rx_s2 && rx_ack) begin
        rx_ack <= 1'b0;
      end
    end
  end

  // Watch req pulses and xdata stability while req is high.
  always @(negedge clk) begin
    if (bus.req && !req_prev) begin
      req_rises++;
      if (ack_mode == 1) pop_check("echo_capture", bus.xdata);
    end
    if (bus.req && (bus.xdata !== cur_data)) xdata_bad++;
    req_prev = bus.req;
  end

  // Offer d until accepted; optionally keep in_valid high with junk data afterwards.
  task automatic send(input logic [W-1:0] d, input bit hold_valid);
    int n;
    n = 0;
    bus.in_valid = 1'b1;
    while (!bus.in_ready && n < LIMIT) begin
      bus.in_data = W'($urandom);
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= LIMIT) check("send_timeout", n, 0);
    bus.in_data = d;
    @(posedge clk);
    exp_q.push_back(d);
    cur_data = d;
    #1;
    if (hold_valid) bus.in_data = ~d;
    else            bus.in_valid = 1'b0;
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!bus.in_ready && n < LIMIT);
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (bus.busy && n < LIMIT) begin
      @(negedge clk);
      n++;
    end
    if (n >= LIMIT) check("done_timeout", n, 0);
  endtask

  task automatic wait_req();
    int n;
    n = 0;
    while (!bus.req && n < LIMIT) begin
      @(negedge clk);
      n++;
    end
    if (n >= LIMIT) check("req_timeout", n, 0);
  endtask

  typedef struct {
    logic [W-1:0] data;
    int           exp_cycles;
    logic [W-1:0] exp_xdata;
    int           exp_count;
  } vec_t;

  vec_t vecs[8];

  initial begin
    logic [W-1:0] vdata [8];
    int cap0, n, bad_req, bad_rdy, bad_x, bad_cyc, bad_idle;
    int halves [2];

    vdata = '{4'hC, 4'h0, 4'hF, 4'h5, 4'hA, 4'h1, 4'hE, 4'h7};
    for (int i = 0; i < 8; i++) begin
      vecs[i].data       = vdata[i];
      vecs[i].exp_cycles = EXP_CYC;
      vecs[i].exp_xdata  = vdata[i];
      vecs[i].exp_count  = 2 + i;
    end
    halves = '{9, 11};

    bus.in_valid = 1'b0;
    bus.in_data  = '0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_in_ready", bus.in_ready, 1);
    check("rst_busy", bus.busy, 0);
    check("rst_req", bus.req, 0);
    check("rst_xdata", bus.xdata, 0);
    check("rst_count", bus.sent_count, 0);

    // Single transfer, accepted on the first edge after reset release
    ack_mode  = 0;
    rx_half   = 9;
    rst       = 1'b1;
    req_rises = 0;
    xdata_bad = 0;
    send(4'hA, 1'b0);
    wait_done();
    exp_count++;
    check("single_count", bus.sent_count, exp_count);
    check("single_req_pulses", req_rises, 1);
    check("single_xdata_stable", xdata_bad, 0);
    check("single_captures", captures, 1);

    // Back-to-back with in_valid held, receivers at periods 18 and 22
    for (int p = 0; p < 2; p++) begin
      rx_half = halves[p];
      cap0 = captures;
      for (int d = 0; d < 16; d++) begin
        send(W'(d), d != 15);
      end
      wait_done();
      exp_count += 16;
      check("b2b_count", bus.sent_count, exp_count);
      check("b2b_captures", captures - cap0, 16);
      check("b2b_queue_empty", exp_q.size(), 0);
      check("b2b_xdata_stable", xdata_bad, 0);
    end

    // Stall: ack held low for 40 cycles
    rx_stall = 1'b1;
    send(4'h5, 1'b1);
    wait_req();
    bad_req = 0; bad_rdy = 0; bad_x = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      bus.in_data = W'($urandom);
      if (!bus.req) bad_req++;
      if (bus.in_ready) bad_rdy++;
      if (bus.xdata !== 4'h5) bad_x++;
    end
    check("stall_req_high", bad_req, 0);
    check("stall_not_ready", bad_rdy, 0);
    check("stall_xdata_held", bad_x, 0);
    check("stall_count_held", bus.sent_count, exp_count);
    bus.in_valid = 1'b0;
    rx_stall = 1'b0;
    wait_done();
    exp_count++;
    check("stall_release_count", bus.sent_count, exp_count);

    // Asynchronous reset in the middle of WAIT_HI
    rx_stall = 1'b1;
    send(4'h9, 1'b0);
    wait_req();
    @(negedge clk);
    #2;
    rst = 1'b0;
    exp_q.delete();
    exp_count = 0;
    #1;
    check("midrst_req", bus.req, 0);
    check("midrst_xdata", bus.xdata, 0);
    check("midrst_count", bus.sent_count, 0);
    check("midrst_in_ready", bus.in_ready, 1);
    check("midrst_busy", bus.busy, 0);
    rx_stall = 1'b0;
    @(negedge clk);
    rst = 1'b1;

    // Spurious ack while idle
    ack_mode  = 2;
    ack_force = 1'b1;
    bad_idle  = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.busy || !bus.in_ready) bad_idle++;
    end
    check("spurious_idle", bad_idle, 0);
    check("spurious_count", bus.sent_count, 0);
    ack_force = 1'b0;
    repeat (3) @(negedge clk);
    ack_mode = 0;
    send(4'h3, 1'b0);
    wait_done();
    exp_count++;
    check("after_spurious_count", bus.sent_count, exp_count);

    // Table-driven transfers with zero-time ack echo
    ack_mode = 1;
    for (int i = 0; i < 8; i++) begin
      send(vecs[i].data, 1'b0);
      wait_ready(n);
      exp_count++;
      check("vec_cycles", n, vecs[i].exp_cycles);
      check("vec_xdata", bus.xdata, vecs[i].exp_xdata);
      check("vec_count", bus.sent_count, vecs[i].exp_count);
    end

    // Wrap the counter at 256 completed transfers
    bad_cyc = 0;
    while (exp_count < 255) begin
      send(W'(exp_count), 1'b0);
      wait_ready(n);
      exp_count++;
      if (n != EXP_CYC) bad_cyc++;
    end
    check("wrap_count_255", bus.sent_count, 255);
    send(4'h6, 1'b0);
    wait_ready(n);
    exp_count = 0;
    check("wrap_last_cycles", n, EXP_CYC);
    check("wrap_count_0", bus.sent_count, 0);
    check("wrap_cycle_errors", bad_cyc, 0);
    check("final_queue_empty", exp_q.size(), 0);
    check("final_xdata_stable", xdata_bad, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
